// File: rtl/pkg_cpu.sv
// Shared types for the CPU memory responder: request sizes, FSM states and
// small decode helpers used by the responder datapath.
package pkg_cpu;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2,
    SZ_48 = 2'd3
  } ReqDataSz;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } RespState;

  // Number of 16-bit RAM beats needed for a request of the given size.
  function automatic logic [1:0] beat_count(input ReqDataSz sz);
    case (sz)
      SZ_32:   beat_count = 2'd2;
      SZ_48:   beat_count = 2'd3;
      default: beat_count = 2'd1;
    endcase
  endfunction

  // Multi-byte accesses must be halfword aligned; fetch-sized writes do not exist.
  function automatic logic is_illegal(input ReqDataSz sz, input logic write, input logic addr0);
    is_illegal = ((sz != SZ_8) && addr0) || ((sz == SZ_48) && write);
  endfunction

endpackage

// File: rtl/PlainAdder.sv
// Unsigned W-bit adder, result wraps modulo 2^W.
module PlainAdder #(
  parameter int W = 31
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/cpu_mem_responder.sv
// Splits CPU byte/halfword/word/fetch requests into 16-bit RAM beats, stalling
// the CPU via cpu_enable while the beats run.
// Handshake: a request is taken only when req_valid=1 in ST_IDLE; the CPU is
// then held (cpu_enable=0) for the whole of ST_BEAT and released in ST_DONE.
module cpu_mem_responder
  import pkg_cpu::*;
#(
  parameter int RAM_ADDR_W = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  cpu_enable,
  output logic [47:0]           rdata,
  output logic                  err,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [1:0]            ram_be,
  output logic [15:0]           ram_wdata,
  input  logic [15:0]           ram_rdata,
  output logic [1:0]            dbg_state
);

  RespState              state_q, state_d;
  logic [1:0]            k_q, k_d;
  ReqDataSz              size_q;
  logic                  write_q;
  logic                  addr0_q;
  logic [31:0]           wdata_q;
  logic [RAM_ADDR_W-1:0] base_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [31:0]           buf_q;
  logic [47:0]           rdata_q;
  logic                  err_q, err_d;

  logic                  accept;
  logic [1:0]            n_beats;
  logic                  beat_active;
  logic [1:0]            k_inc;
  logic [RAM_ADDR_W-1:0] next_addr;
  logic [47:0]           rd_final;

  assign n_beats = beat_count(size_q);
  assign k_inc   = k_q + 2'd1;

  PlainAdder #(.W(RAM_ADDR_W)) u_addr_add (
    .a_i   (base_q),
    .b_i   ({{(RAM_ADDR_W-2){1'b0}}, k_inc}),
    .sum_o (next_addr)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_illegal(ReqDataSz'(req_size), req_write, req_addr[0])) begin
            err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            k_d     = 2'd0;
            state_d = ST_BEAT;
          end
        end
      end
      ST_BEAT: begin
        // Reads spend one extra cycle here to catch the last RAM data beat.
        if (write_q ? (k_q == n_beats - 2'd1) : (k_q == n_beats)) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_final = 48'd0;
    case (size_q)
      SZ_8:    rd_final = {40'd0, (addr0_q ? ram_rdata[15:8] : ram_rdata[7:0])};
      SZ_16:   rd_final = {32'd0, ram_rdata};
      SZ_32:   rd_final = {16'd0, ram_rdata, buf_q[15:0]};
      default: rd_final = {ram_rdata, buf_q};
    endcase
  end

  assign beat_active = (state_q == ST_BEAT) && (k_q < n_beats);

  always_comb begin
    ram_we    = beat_active && write_q;
    ram_be    = 2'b00;
    ram_wdata = 16'd0;
    if (beat_active) begin
      if (write_q && (size_q == SZ_8)) begin
        ram_be = addr0_q ? 2'b10 : 2'b01;
      end else begin
        ram_be = 2'b11;
      end
    end
    if (ram_we) begin
      if (size_q == SZ_8) begin
        ram_wdata = {wdata_q[7:0], wdata_q[7:0]};
      end else begin
        ram_wdata = k_q[0] ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      size_q  <= SZ_8;
      write_q <= 1'b0;
      addr0_q <= 1'b0;
      wdata_q <= 32'd0;
      base_q  <= '0;
      addr_q  <= '0;
      buf_q   <= 32'd0;
      rdata_q <= 48'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
      if (accept) begin
        size_q  <= ReqDataSz'(req_size);
        write_q <= req_write;
        addr0_q <= req_addr[0];
        wdata_q <= req_wdata;
        base_q  <= req_addr[RAM_ADDR_W:1];
        addr_q  <= req_addr[RAM_ADDR_W:1];
      end
      if ((state_q == ST_BEAT) && (k_q < n_beats - 2'd1)) begin
        addr_q <= next_addr;
      end
      // RAM data for beat k-1 arrives while the FSM sits at beat k.
      if ((state_q == ST_BEAT) && !write_q && (k_q != 2'd0)) begin
        if (k_q == n_beats) begin
          rdata_q <= rd_final;
        end else if (k_q == 2'd1) begin
          buf_q[15:0] <= ram_rdata;
        end else begin
          buf_q[31:16] <= ram_rdata;
        end
      end
    end
  end

  assign cpu_enable = (state_q != ST_BEAT);
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign ram_addr   = addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with a behavioural 16-bit RAM that
// returns read data one cycle after the address.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        cpu_enable;
  logic [47:0] rdata;
  logic        err;
  logic [30:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'd0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  int          stall_cnt, err_cnt, we_cnt;
  logic        addr_moved;
  logic [30:0] addr_log[$];
  logic [1:0]  be_log[$];
  logic [15:0] wd_log[$];

  logic [15:0] mem [logic [30:0]];

  cpu_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .cpu_enable (cpu_enable),
    .rdata      (rdata),
    .err        (err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_rd(input logic [30:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    logic [15:0] cur;
    cur = mem_rd(ram_addr);
    ram_rdata <= cur;
    if (ram_we) begin
      if (ram_be[0]) cur[7:0]  = ram_wdata[7:0];
      if (ram_be[1]) cur[15:8] = ram_wdata[15:8];
      mem[ram_addr] = cur;
    end
  end

  // One request, then a fixed 12-cycle observation window sampled on negedges.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input bit inj);
    logic [30:0] a0;
    @(negedge clk);
    a0 = ram_addr;
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    stall_cnt = 0; err_cnt = 0; we_cnt = 0; addr_moved = 1'b0;
    addr_log.delete(); be_log.delete(); wd_log.delete();
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (inj && c == 0) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_addr = 32'h62; req_wdata = 32'h77;
      end
      if (inj && c == 1) req_valid = 1'b0;
      if (err) err_cnt++;
      if (!cpu_enable) stall_cnt++;
      if (ram_we) we_cnt++;
      if (ram_addr !== a0) addr_moved = 1'b1;
      if (ram_be != 2'b00) begin
        addr_log.push_back(ram_addr);
        be_log.push_back(ram_be);
        wd_log.push_back(ram_wdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (cpu_enable !== 1'b1) $display("FAIL reset_cpu_enable: got %b want 1", cpu_enable); else n_pass++;
    n_checks++; if (rdata !== 48'd0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (ram_be !== 2'b00) $display("FAIL reset_ram_be: got %b want 00", ram_be); else n_pass++;
    n_checks++; if (ram_addr !== 31'd0) $display("FAIL reset_ram_addr: got %h want 0", ram_addr); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_read32();
    mem[31'h80] = 16'hBEEF; mem[31'h81] = 16'hDEAD;
    run_req(1'b0, 2'd2, 32'h100, 32'd0, 1'b0);
    n_checks++; if (stall_cnt != 3) $display("FAIL read32_stall: got %0d want 3", stall_cnt); else n_pass++;
    n_checks++; if (rdata !== 48'h0000_DEAD_BEEF) $display("FAIL read32_rdata: got %h want 0000deadbeef", rdata); else n_pass++;
    n_checks++; if (addr_log.size() != 2) $display("FAIL read32_beats: got %0d want 2", addr_log.size()); else n_pass++;
    n_checks++; if (addr_log[0] !== 31'h80 || addr_log[1] !== 31'h81)
      $display("FAIL read32_addrs: got %h,%h want 80,81", addr_log[0], addr_log[1]); else n_pass++;
    n_checks++; if (we_cnt != 0) $display("FAIL read32_we: got %0d want 0", we_cnt); else n_pass++;
  endtask

  task automatic test_fetch48();
    mem[31'h1] = 16'h1111; mem[31'h2] = 16'h2222; mem[31'h3] = 16'h3333;
    run_req(1'b0, 2'd3, 32'h2, 32'd0, 1'b0);
    n_checks++; if (stall_cnt != 4) $display("FAIL fetch48_stall: got %0d want 4", stall_cnt); else n_pass++;
    n_checks++; if (rdata !== 48'h3333_2222_1111) $display("FAIL fetch48_rdata: got %h want 333322221111", rdata); else n_pass++;
  endtask

  task automatic test_read16();
    mem[31'h10] = 16'h5AA5;
    run_req(1'b0, 2'd1, 32'h20, 32'd0, 1'b0);
    n_checks++; if (stall_cnt != 2) $display("FAIL read16_stall: got %0d want 2", stall_cnt); else n_pass++;
    n_checks++; if (rdata !== 48'h0000_0000_5AA5) $display("FAIL read16_rdata: got %h want 000000005aa5", rdata); else n_pass++;
  endtask

  task automatic test_write8();
    mem[31'h3] = 16'h1234;
    run_req(1'b1, 2'd0, 32'h7, 32'h0000_00A5, 1'b0);
    n_checks++; if (stall_cnt != 1) $display("FAIL write8_stall: got %0d want 1", stall_cnt); else n_pass++;
    n_checks++; if (we_cnt != 1) $display("FAIL write8_we: got %0d want 1", we_cnt); else n_pass++;
    n_checks++; if (addr_log[0] !== 31'h3) $display("FAIL write8_addr: got %h want 3", addr_log[0]); else n_pass++;
    n_checks++; if (be_log[0] !== 2'b10) $display("FAIL write8_be: got %b want 10", be_log[0]); else n_pass++;
    n_checks++; if (wd_log[0] !== 16'hA5A5) $display("FAIL write8_wdata: got %h want a5a5", wd_log[0]); else n_pass++;
    n_checks++; if (mem_rd(31'h3) !== 16'hA534) $display("FAIL write8_mem: got %h want a534", mem_rd(31'h3)); else n_pass++;
    n_checks++; if (rdata !== 48'h0000_0000_5AA5) $display("FAIL write8_rdata_hold: got %h want 000000005aa5", rdata); else n_pass++;
  endtask

  task automatic test_read8();
    run_req(1'b0, 2'd0, 32'h7, 32'd0, 1'b0);
    n_checks++; if (stall_cnt != 2) $display("FAIL read8_stall: got %0d want 2", stall_cnt); else n_pass++;
    n_checks++; if (rdata !== 48'h0000_0000_00A5) $display("FAIL read8_hi: got %h want a5", rdata); else n_pass++;
    run_req(1'b0, 2'd0, 32'h6, 32'd0, 1'b0);
    n_checks++; if (rdata !== 48'h0000_0000_0034) $display("FAIL read8_lo: got %h want 34", rdata); else n_pass++;
  endtask

  task automatic test_illegal();
    run_req(1'b0, 2'd1, 32'h5, 32'd0, 1'b0);
    n_checks++; if (err_cnt != 1) $display("FAIL illegal16_err: got %0d want 1", err_cnt); else n_pass++;
    n_checks++; if (stall_cnt != 0) $display("FAIL illegal16_stall: got %0d want 0", stall_cnt); else n_pass++;
    n_checks++; if (we_cnt != 0) $display("FAIL illegal16_we: got %0d want 0", we_cnt); else n_pass++;
    n_checks++; if (addr_moved !== 1'b0) $display("FAIL illegal16_addr: got moved=%b want 0", addr_moved); else n_pass++;
    n_checks++; if (rdata !== 48'h0000_0000_0034) $display("FAIL illegal16_rdata: got %h want 34", rdata); else n_pass++;
    run_req(1'b1, 2'd3, 32'h0, 32'h1234_5678, 1'b0);
    n_checks++; if (err_cnt != 1 || we_cnt != 0 || stall_cnt != 0)
      $display("FAIL illegal48w: got err=%0d we=%0d stall=%0d want 1,0,0", err_cnt, we_cnt, stall_cnt); else n_pass++;
    run_req(1'b0, 2'd2, 32'h3, 32'd0, 1'b0);
    n_checks++; if (err_cnt != 1 || stall_cnt != 0 || addr_moved !== 1'b0)
      $display("FAIL illegal32r: got err=%0d stall=%0d moved=%b want 1,0,0", err_cnt, stall_cnt, addr_moved); else n_pass++;
  endtask

  task automatic test_write32();
    run_req(1'b1, 2'd2, 32'h10, 32'hCAFE_F00D, 1'b0);
    n_checks++; if (stall_cnt != 2) $display("FAIL write32_stall: got %0d want 2", stall_cnt); else n_pass++;
    n_checks++; if (addr_log.size() != 2) $display("FAIL write32_beats: got %0d want 2", addr_log.size()); else n_pass++;
    n_checks++; if (addr_log[0] !== 31'h8 || addr_log[1] !== 31'h9)
      $display("FAIL write32_addrs: got %h,%h want 8,9", addr_log[0], addr_log[1]); else n_pass++;
    n_checks++; if (wd_log[0] !== 16'hF00D || wd_log[1] !== 16'hCAFE)
      $display("FAIL write32_wdata: got %h,%h want f00d,cafe", wd_log[0], wd_log[1]); else n_pass++;
    n_checks++; if (be_log[0] !== 2'b11 || be_log[1] !== 2'b11)
      $display("FAIL write32_be: got %b,%b want 11,11", be_log[0], be_log[1]); else n_pass++;
    run_req(1'b0, 2'd2, 32'h10, 32'd0, 1'b0);
    n_checks++; if (rdata !== 48'h0000_CAFE_F00D) $display("FAIL write32_readback: got %h want 0000cafef00d", rdata); else n_pass++;
  endtask

  task automatic test_reset_mid_beat();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ram_we !== 1'b1 || ram_addr !== 31'h21)
      $display("FAIL midrst_beat1: got we=%b addr=%h want 1,21", ram_we, ram_addr); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (ram_we !== 1'b0) $display("FAIL midrst_we: got %b want 0", ram_we); else n_pass++;
    n_checks++; if (cpu_enable !== 1'b1) $display("FAIL midrst_enable: got %b want 1", cpu_enable); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL midrst_state: got %0d want 0", dbg_state); else n_pass++;
    n_checks++; if (rdata !== 48'd0) $display("FAIL midrst_rdata: got %h want 0", rdata); else n_pass++;
    rst_n = 1'b1;
    run_req(1'b0, 2'd2, 32'h100, 32'd0, 1'b0);
    n_checks++; if (stall_cnt != 3 || rdata !== 48'h0000_DEAD_BEEF)
      $display("FAIL midrst_next: got stall=%0d rdata=%h want 3,0000deadbeef", stall_cnt, rdata); else n_pass++;
  endtask

  task automatic test_wrap();
    mem[31'h7FFF_FFFF] = 16'h7777; mem[31'h0] = 16'h0101;
    run_req(1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0, 1'b0);
    n_checks++; if (addr_log[0] !== 31'h7FFF_FFFF || addr_log[1] !== 31'h0)
      $display("FAIL wrap_addrs: got %h,%h want 7fffffff,0", addr_log[0], addr_log[1]); else n_pass++;
    n_checks++; if (rdata !== 48'h0000_0101_7777) $display("FAIL wrap_rdata: got %h want 000001017777", rdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 2'd2, 32'h100, 32'd0, 1'b1);
    n_checks++; if (we_cnt != 0) $display("FAIL busy_ignore_we: got %0d want 0", we_cnt); else n_pass++;
    n_checks++; if (stall_cnt != 3) $display("FAIL busy_ignore_stall: got %0d want 3", stall_cnt); else n_pass++;
    n_checks++; if (rdata !== 48'h0000_DEAD_BEEF) $display("FAIL busy_ignore_rdata: got %h want 0000deadbeef", rdata); else n_pass++;
    n_checks++; if (mem_rd(31'h31) !== 16'h0000) $display("FAIL busy_ignore_mem: got %h want 0", mem_rd(31'h31)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read32();
    test_fetch48();
    test_read16();
    test_write8();
    test_read8();
    test_illegal();
    test_write32();
    test_reset_mid_beat();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter RAM_ADDR_W, default 31: width of the halfword address into backing RAM.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  CPU memory request present this cycle.
REQ-005 req_write  in  1  1 = write, 0 = read.
REQ-006 req_size  in  2  pkg_cpu::ReqDataSz: 0 = 8b, 1 = 16b, 2 = 32b, 3 = 48b (instruction fetch).
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  write data, little-endian.
REQ-009 cpu_enable  out  1  drives the CPU enable; 0 stalls the CPU.
REQ-010 rdata  out  48  read data to the CPU data input bus.
REQ-011 err  out  1  one-cycle pulse on a rejected request.
REQ-012 ram_addr  out  RAM_ADDR_W  halfword address.
REQ-013 ram_we  out  1  RAM write strobe.
REQ-014 ram_be  out  2  byte enables; bit0 is the low byte.
REQ-015 ram_wdata  out  16  RAM write data.
REQ-016 ram_rdata  in  16  RAM read data, valid exactly one cycle after its address is presented.

Function
REQ-017 FSM states SHALL be ST_IDLE, ST_BEAT and ST_DONE.
REQ-018 ST_IDLE with req_valid=1 and a legal request SHALL latch size, base = req_addr[31:1], write flag and wdata; clear beat counter k; go to ST_BEAT; drive cpu_enable=0 from the next cycle.
REQ-019 Beat count N SHALL be: 8b = 1, 16b = 1, 32b = 2, 48b = 3.
REQ-020 In ST_BEAT, beat k SHALL drive ram_addr = base+k (modulo 2^RAM_ADDR_W, wrap allowed); after the last beat the FSM SHALL go to ST_DONE.
REQ-021 Read data: ram_rdata returned for beat k SHALL be captured into rdata[16k+15:16k]; a 16b or 32b read SHALL zero unused upper rdata bits.
REQ-022 8b read: byte lane req_addr[0] (0 = low, 1 = high) SHALL be zero-extended into rdata.
REQ-023 Writes: beat k SHALL drive ram_we=1, ram_be=2'b11 and ram_wdata = wdata[16k+15:16k].
REQ-024 8b write: ram_be SHALL be 2'b01 when addr[0]=0 and 2'b10 when addr[0]=1; ram_wdata = {wdata[7:0], wdata[7:0]}.
REQ-025 Stall length: cpu_enable SHALL be 0 for exactly N+1 cycles on reads and N cycles on writes.
REQ-026 ST_DONE SHALL last one cycle with cpu_enable=1, then return to ST_IDLE.
REQ-027 rdata SHALL hold its value until the next read completes; writes SHALL not alter it.
REQ-028 Illegal request (size != 8b with req_addr[0]=1, or a 48b write): err=1 for one cycle, no RAM access, cpu_enable stays 1, rdata unchanged, state stays ST_IDLE.
REQ-029 req_valid outside ST_IDLE SHALL be ignored.
REQ-030 ram_we SHALL be 0 in every state except a write beat in ST_BEAT.

Reset
REQ-031 With rst_n=0 at a clock edge: state = ST_IDLE, cpu_enable=1, rdata=0, err=0, ram_we=0, ram_be=0, ram_addr=0, k=0.
REQ-032 Reset during ST_BEAT SHALL abort the transfer; ram_we SHALL be 0 from that edge onward.

Structure
REQ-033 The ReqDataSz enum and a new RespState enum SHALL live in pkg_cpu.
REQ-034 The beat address increment SHALL use one PlainAdder instance; no other sub-module.

Verification
REQ-035 32b read at addr 0x100, RAM[0x80]=0xBEEF, RAM[0x81]=0xDEAD -> cpu_enable low 3 cycles, then rdata = 0x0000_DEAD_BEEF.
REQ-036 48b fetch at addr 0x2, RAM halfwords 1..3 = 0x1111, 0x2222, 0x3333 -> cpu_enable low 4 cycles, rdata = 0x3333_2222_1111.
REQ-037 8b write of 0xA5 at addr 0x7 -> one beat: ram_addr=0x3, ram_be=2'b10, ram_wdata=0xA5A5, cpu_enable low 1 cycle.
REQ-038 16b read at addr 0x5 -> err pulse for 1 cycle, ram_we=0 and ram_addr unchanged throughout, cpu_enable stays 1.
REQ-039 32b write at addr 0x10, rst_n=0 asserted during beat 1 -> ram_we=0 from the reset edge, cpu_enable=1, next request serviced normally.
REQ-040 32b read at addr 0xFFFF_FFFE -> beat addresses 0x7FFF_FFFF then 0x0000_0000 (wrap).
